// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: sends one scan code as one 11-bit frame,
// or as the break prefix 0xF0 followed by the code for a release request.
module ps2_kbd_tx #(
    parameter int HALF = 2000,
    parameter int GAP  = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       isRelease,
    input  logic       send_valid,
    output logic       send_ready,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;

    state_t         state_q, state_n;
    logic [HW-1:0]  half_q, half_n;
    logic [3:0]     bit_q, bit_n;
    logic [GW-1:0]  gap_q, gap_n;
    logic           low_q, low_n;
    logic           pre_q, pre_n;
    logic           clk_q, clk_n;
    logic           data_q, data_n;
    logic           ready_q, ready_n;
    logic           done_q, done_n;
    logic [7:0]     tx_byte_q, tx_byte_n;
    logic [7:0]     code_q, code_n;

    // Bit idx of an 11-bit frame: start, eight data bits LSB first, odd parity, stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] b);
        logic v;
        case (idx)
            4'd0:    v = 1'b0;
            4'd9:    v = ~^b;
            4'd10:   v = 1'b1;
            default: v = b[3'(idx - 4'd1)];
        endcase
        return v;
    endfunction

    always_comb begin
        state_n   = state_q;
        half_n    = half_q;
        bit_n     = bit_q;
        gap_n     = gap_q;
        low_n     = low_q;
        pre_n     = pre_q;
        clk_n     = clk_q;
        data_n    = data_q;
        done_n    = 1'b0;
        tx_byte_n = tx_byte_q;
        code_n    = code_q;

        case (state_q)
            S_IDLE: begin
                if (send_valid && ready_q) begin
                    code_n    = code;
                    tx_byte_n = isRelease ? 8'hF0 : code;
                    pre_n     = isRelease;
                    state_n   = S_FRAME;
                    half_n    = '0;
                    bit_n     = 4'd0;
                    low_n     = 1'b0;
                    clk_n     = 1'b1;
                    data_n    = 1'b0;
                end
            end
            S_FRAME: begin
                if (half_q == HW'(HALF - 1)) begin
                    half_n = '0;
                    if (!low_q) begin
                        low_n = 1'b1;
                        clk_n = 1'b0;
                    end else begin
                        low_n = 1'b0;
                        clk_n = 1'b1;
                        if (bit_q == 4'd10) begin
                            state_n = S_GAP;
                            gap_n   = '0;
                            data_n  = 1'b1;
                        end else begin
                            bit_n  = bit_q + 4'd1;
                            data_n = frame_bit(bit_q + 4'd1, tx_byte_q);
                        end
                    end
                end else begin
                    half_n = half_q + HW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    gap_n = '0;
                    // The break prefix has gone out; the real code follows after the idle gap.
                    if (pre_q) begin
                        pre_n     = 1'b0;
                        tx_byte_n = code_q;
                        state_n   = S_FRAME;
                        half_n    = '0;
                        bit_n     = 4'd0;
                        low_n     = 1'b0;
                        data_n    = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    gap_n = gap_q + GW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        ready_n = (state_n == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            half_q  <= '0;
            bit_q   <= 4'd0;
            gap_q   <= '0;
            low_q   <= 1'b0;
            pre_q   <= 1'b0;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            half_q  <= half_n;
            bit_q   <= bit_n;
            gap_q   <= gap_n;
            low_q   <= low_n;
            pre_q   <= pre_n;
            clk_q   <= clk_n;
            data_q  <= data_n;
            ready_q <= ready_n;
            done_q  <= done_n;
        end
    end

    always_ff @(posedge clk) begin
        tx_byte_q <= tx_byte_n;
        code_q    <= code_n;
    end

    assign send_ready = ready_q;
    assign done       = done_q;
    assign ps2_clk    = clk_q;
    assign ps2_data   = data_q;

endmodule
